multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: the number of consecutive not-ready cycles in a wait state before a fault.
REQ-002 SHALL have port CLK  in  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port Op  in  6  instruction opcode, taken from the instruction register.
REQ-005 SHALL have port Zero  in  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-007 SHALL have ports IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1  datapath controls.
REQ-008 SHALL have ports ALUSrcB, ALUOp, PCSrc  out  2  datapath mux and ALU controls.
REQ-009 SHALL have port PCEn  out  1  PC load enable.
REQ-010 SHALL have port retire  out  1  one-cycle pulse when an instruction completes.
REQ-011 SHALL have port fault  out  1  high while the block is in the FAULT state.
REQ-012 SHALL have port state  out  4  current state code, for debug.

Function
REQ-013 SHALL be a Moore FSM: outputs decode from the state register only, except enables qualified by mem_ready or Zero.
REQ-014 SHALL encode states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=15.
REQ-015 SHALL drive every output not listed for a state to 0.
REQ-016 SHALL drive FETCH as: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCEn=mem_ready; hold in FETCH until mem_ready=1, then go to DECODE.
REQ-017 SHALL drive DECODE as ALUSrcA=0, ALUSrcB=11, ALUOp=00, and branch on Op: 100011 or 101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->FAULT.
REQ-018 SHALL drive MEMADR as ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD if Op=100011, else MEMWR.
REQ-019 SHALL drive MEMRD as IorD=1, hold until mem_ready=1, then go to MEMWB.
REQ-020 SHALL drive MEMWB as RegDst=0, MemtoReg=1, RegWrite=1, retire=1, then go to FETCH.
REQ-021 SHALL drive MEMWR as IorD=1, MemWrite=1 for every cycle of the state, hold until mem_ready=1, then go to FETCH with retire=1 in the mem_ready cycle.
REQ-022 SHALL drive EXECUTE as ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB; ALUWB SHALL drive RegDst=1, RegWrite=1, retire=1, then go to FETCH.
REQ-023 SHALL drive BRANCH as ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero, retire=1, then go to FETCH.
REQ-024 SHALL drive ADDIEX as ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB; ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1, retire=1, then go to FETCH.
REQ-025 SHALL drive JUMP as PCSrc=10, PCEn=1, retire=1, then go to FETCH.
REQ-026 SHALL run a wait counter that increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0, and clears on mem_ready=1 or any state change.
REQ-027 SHALL go to FAULT when the wait counter reaches MEM_TIMEOUT-1 while mem_ready=0; mem_ready=1 in that same cycle SHALL take precedence (normal completion).
REQ-028 SHALL hold FAULT with fault=1 and all enables 0 until reset.
REQ-029 SHALL have a zero-wait latency of FETCH to retire of 5 cycles for lw, 4 for sw, R-type and addi, and 3 for beq and j.

Reset
REQ-030 SHALL on reset assertion immediately set state=FETCH, clear the wait counter to 0, and force PCEn, IRWrite, MemWrite, RegWrite, retire and fault to 0 while reset is high, regardless of mem_ready.
REQ-031 SHALL on reset mid-instruction abandon the instruction with no retire pulse and start at FETCH on the first edge after deassertion.

Structure
REQ-032 SHALL place the state encoding, the opcode constants (LW, SW, RTYPE, BEQ, ADDI, J) and the ALUOp codes in the shared package mips_pkg.
REQ-033 SHALL implement the wait counter as sub-module mem_wait_timer, parameterised by MEM_TIMEOUT, with ports for clear, count enable and expire.

Verification
REQ-034 SHALL verify: lw (Op=100011) with mem_ready=1 -> states 0,1,2,3,4, RegWrite=MemtoReg=1 in cycle 5, one retire pulse.
REQ-035 SHALL verify: beq with Zero=1 -> PCEn=1 and PCSrc=01 in state 8; repeated with Zero=0 -> PCEn=0, retire=1.
REQ-036 SHALL verify: sw with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, retire only on the 4th.
REQ-037 SHALL verify: MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT (state=15, fault=1) after 4 cycles, remains there until reset.
REQ-038 SHALL verify: Op=111111 in DECODE -> FAULT next cycle, no RegWrite or PCEn.
REQ-039 SHALL verify: reset pulsed during EXECUTE -> state=0 immediately, no retire, normal fetch afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller:
// state codes, opcodes and ALUOp encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        FAULT   = 4'd15
    } state_t;

    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that stall on the memory handshake.
    function automatic logic is_wait_state(state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles and flags the last tolerated one.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expire_o
);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Stall counter: clear has priority so a completed access never counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (cnt_en_i)
            cnt_q <= cnt_q + 1'b1;
    end

    assign expire_o = cnt_en_i && (cnt_q == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-stall timeout and fault trap.
module multi_cycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       retire,
    output logic       fault,
    output logic [3:0] state
);
    state_t state_q;
    logic   stall, tmo;

    // A stall cycle is a wait state with memory not ready; anything else
    // (ready, other state, or the trap itself) restarts the count.
    assign stall = is_wait_state(state_q) && !mem_ready;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk_i    (CLK),
        .rst_i    (reset),
        .clr_i    (!stall || tmo),
        .cnt_en_i (stall),
        .expire_o (tmo)
    );

    // State register and transitions; mem_ready wins over a same-cycle timeout.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:   if (mem_ready) state_q <= DECODE;
                         else if (tmo) state_q <= FAULT;
                DECODE:
                    case (Op)
                        LW, SW:  state_q <= MEMADR;
                        RTYPE:   state_q <= EXECUTE;
                        BEQ:     state_q <= BRANCH;
                        ADDI:    state_q <= ADDIEX;
                        J:       state_q <= JUMP;
                        default: state_q <= FAULT;
                    endcase
                MEMADR:  state_q <= (Op == LW) ? MEMRD : MEMWR;
                MEMRD:   if (mem_ready) state_q <= MEMWB;
                         else if (tmo) state_q <= FAULT;
                MEMWR:   if (mem_ready) state_q <= FETCH;
                         else if (tmo) state_q <= FAULT;
                EXECUTE: state_q <= ALUWB;
                ADDIEX:  state_q <= ADDIWB;
                MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_q <= FETCH;
                FAULT:   state_q <= FAULT;
                default: state_q <= FAULT;
            endcase
        end
    end

    // Moore output decode; handshake-qualified enables use mem_ready/Zero,
    // and all write/side-effect enables are held low during reset.
    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = ALUOP_ADD;
        PCSrc    = 2'b00;
        PCEn     = 1'b0;
        retire   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            FETCH:   begin ALUSrcB = 2'b01; IRWrite = mem_ready; PCEn = mem_ready; end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            MEMRD:   IorD = 1'b1;
            MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; retire = 1'b1; end
            MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; retire = mem_ready; end
            EXECUTE: begin ALUSrcA = 1'b1; ALUOp = ALUOP_FUNCT; end
            ALUWB:   begin RegDst = 1'b1; RegWrite = 1'b1; retire = 1'b1; end
            BRANCH:  begin
                ALUSrcA = 1'b1; ALUOp = ALUOP_SUB; PCSrc = 2'b01;
                PCEn = Zero; retire = 1'b1;
            end
            ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            ADDIWB:  begin RegWrite = 1'b1; retire = 1'b1; end
            JUMP:    begin PCSrc = 2'b10; PCEn = 1'b1; retire = 1'b1; end
            FAULT:   fault = 1'b1;
            default: fault = 1'b1;
        endcase
        if (reset) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            retire   = 1'b0;
            fault    = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: vector table, hand-written corner sequences,
// and random traffic against an instruction-sequence reference model.
module tb_multi_cycle_ctrl;
    import mips_pkg::*;

    localparam int TO = 4;

    logic       CLK = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero, mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, retire, fault;
    logic [3:0] state;

    multi_cycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .retire(retire), .fault(fault), .state(state)
    );

    always #5 CLK = ~CLK;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
        reset = r; Op = op; Zero = z; mem_ready = mr;
    endtask

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z, mr;
        logic [3:0] st;
        logic       ret, pcen, rw, mw, m2r, flt;
        logic [1:0] pcsrc;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // Tracks the remaining list of states for the instruction in flight and
    // how many cycles have been spent stalled on memory.
    int m_cur;
    int m_seq[$];
    int m_wait;

    function automatic void m_reset();
        m_cur = 0; m_seq.delete(); m_wait = 0;
    endfunction

    function automatic void m_route(input logic [5:0] op);
        m_seq.delete();
        if (op == LW)         m_seq = '{2, 3, 4};
        else if (op == SW)    m_seq = '{2, 5};
        else if (op == RTYPE) m_seq = '{6, 7};
        else if (op == BEQ)   m_seq = '{8};
        else if (op == ADDI)  m_seq = '{9, 10};
        else if (op == J)     m_seq = '{11};
        else                  m_seq = '{15};
    endfunction

    function automatic void m_advance();
        m_wait = 0;
        if (m_seq.size() == 0) m_cur = 0;
        else m_cur = m_seq.pop_front();
    endfunction

    function automatic void m_step(input logic r, input logic [5:0] op, input logic mr);
        if (r) begin
            m_reset();
        end else if (m_cur == 15) begin
            m_cur = 15;
        end else if (m_cur == 0 || m_cur == 3 || m_cur == 5) begin
            if (mr) begin
                if (m_cur == 0) begin m_cur = 1; m_wait = 0; end
                else m_advance();
            end else begin
                m_wait++;
                if (m_wait == TO) begin m_cur = 15; m_wait = 0; end
            end
        end else if (m_cur == 1) begin
            m_route(op);
            m_advance();
        end else begin
            m_advance();
        end
    endfunction

    function automatic logic [19:0] expect_out(input int st, input logic rst,
                                               input logic mr, input logic z);
        logic iord, mw, irw, rd, m2r, rw, asa, pcen, ret, flt;
        logic [1:0] asb, aop, pcs;
        iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0;
        pcen = 0; ret = 0; flt = 0; asb = 0; aop = 0; pcs = 0;
        case (st)
            0:  begin asb = 2'd1; irw = mr; pcen = mr; end
            1:  asb = 2'd3;
            2:  begin asa = 1; asb = 2'd2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin iord = 1; mw = 1; ret = mr; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rd = 1; rw = 1; ret = 1; end
            8:  begin asa = 1; aop = 2'd1; pcs = 2'd1; pcen = z; ret = 1; end
            9:  begin asa = 1; asb = 2'd2; end
            10: begin rw = 1; ret = 1; end
            11: begin pcs = 2'd2; pcen = 1; ret = 1; end
            15: flt = 1;
            default: ;
        endcase
        if (rst) begin pcen = 0; irw = 0; mw = 0; rw = 0; ret = 0; flt = 0; end
        return {iord, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pcen, ret, flt, 4'(st)};
    endfunction

    logic [19:0] act_vec;
    assign act_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                      ALUSrcB, ALUOp, PCSrc, PCEn, retire, fault, state};

    initial begin
        logic [5:0] rop;
        logic       rr, rz, rmr;
        int         k;

        // fields: rst, op, z, mr, st, ret, pcen, rw, mw, m2r, flt, pcsrc
        tbl.push_back('{0, LW, 0, 1,  0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, LW, 0, 1,  1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, LW, 0, 1,  2, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, LW, 0, 1,  3, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, LW, 0, 1,  4, 1, 0, 1, 0, 1, 0, 2'd0});
        tbl.push_back('{0, BEQ, 1, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, BEQ, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, BEQ, 1, 1, 8, 1, 1, 0, 0, 0, 0, 2'd1});
        tbl.push_back('{0, BEQ, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, BEQ, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, BEQ, 0, 1, 8, 1, 0, 0, 0, 0, 0, 2'd1});
        tbl.push_back('{0, SW, 0, 1,  0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 1,  1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 1,  2, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 0,  5, 0, 0, 0, 1, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 0,  5, 0, 0, 0, 1, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 0,  5, 0, 0, 0, 1, 0, 0, 2'd0});
        tbl.push_back('{0, SW, 0, 1,  5, 1, 0, 0, 1, 0, 0, 2'd0});
        tbl.push_back('{0, 6'h3F, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, 6'h3F, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, 6'h3F, 0, 1, 15, 0, 0, 0, 0, 0, 1, 2'd0});
        tbl.push_back('{0, 6'h3F, 0, 1, 15, 0, 0, 0, 0, 0, 1, 2'd0});
        tbl.push_back('{1, RTYPE, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, RTYPE, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, RTYPE, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, RTYPE, 0, 1, 6, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, RTYPE, 0, 1, 7, 1, 0, 1, 0, 0, 0, 2'd0});
        tbl.push_back('{0, ADDI, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, ADDI, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, ADDI, 0, 1, 9, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, ADDI, 0, 1, 10, 1, 0, 1, 0, 0, 0, 2'd0});
        tbl.push_back('{0, J, 0, 1,   0, 0, 1, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, J, 0, 1,   1, 0, 0, 0, 0, 0, 0, 2'd0});
        tbl.push_back('{0, J, 0, 1,  11, 1, 1, 0, 0, 0, 0, 2'd2});

        // Reset state: enables forced low even with mem_ready high.
        drive(1, RTYPE, 0, 1);
        @(negedge CLK);
        chk("reset_state", state, 0);
        chk("reset_pcen", PCEn, 0);
        chk("reset_irwrite", IRWrite, 0);
        chk("reset_retire", retire, 0);

        // Table-driven vectors, one cycle per row.
        foreach (tbl[i]) begin
            next_cyc();
            drive(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
            @(negedge CLK);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_retire", i), retire, tbl[i].ret);
            chk($sformatf("tbl%0d_pcen", i), PCEn, tbl[i].pcen);
            chk($sformatf("tbl%0d_regwrite", i), RegWrite, tbl[i].rw);
            chk($sformatf("tbl%0d_memwrite", i), MemWrite, tbl[i].mw);
            chk($sformatf("tbl%0d_memtoreg", i), MemtoReg, tbl[i].m2r);
            chk($sformatf("tbl%0d_fault", i), fault, tbl[i].flt);
            chk($sformatf("tbl%0d_pcsrc", i), PCSrc, tbl[i].pcsrc);
        end

        // Timeout in FETCH: four stalled cycles, then trapped until reset.
        for (int c = 0; c < TO; c++) begin
            next_cyc();
            drive(0, RTYPE, 0, 0);
            @(negedge CLK);
            chk($sformatf("tmo_wait%0d_state", c), state, 0);
        end
        for (int c = 0; c < 3; c++) begin
            next_cyc();
            drive(0, RTYPE, 0, 1);
            @(negedge CLK);
            chk($sformatf("tmo_hold%0d_state", c), state, 15);
            chk($sformatf("tmo_hold%0d_fault", c), fault, 1);
            chk($sformatf("tmo_hold%0d_pcen", c), PCEn, 0);
        end
        next_cyc();
        drive(1, RTYPE, 0, 1);
        @(negedge CLK);
        chk("tmo_reset_state", state, 0);
        chk("tmo_reset_fault", fault, 0);

        // Reset pulsed asynchronously during EXECUTE.
        next_cyc();
        drive(0, RTYPE, 0, 1);
        next_cyc();
        next_cyc();
        @(negedge CLK);
        chk("exrst_pre_state", state, 6);
        #1 reset = 1'b1;
        #1;
        chk("exrst_async_state", state, 0);
        chk("exrst_async_retire", retire, 0);
        @(negedge CLK);
        chk("exrst_held_state", state, 0);
        chk("exrst_held_regwrite", RegWrite, 0);
        next_cyc();
        drive(0, RTYPE, 0, 1);
        @(negedge CLK);
        chk("exrst_fetch_state", state, 0);
        chk("exrst_fetch_pcen", PCEn, 1);
        next_cyc();
        @(negedge CLK);
        chk("exrst_decode_state", state, 1);

        // Random traffic against the reference model.
        next_cyc();
        drive(1, RTYPE, 0, 0);
        m_reset();
        rop = RTYPE;
        for (int c = 0; c < 2000; c++) begin
            next_cyc();
            rr = (m_cur == 15) || ($urandom_range(0, 99) == 0);
            if (rr) m_reset();
            if (m_cur == 0) begin
                k = $urandom_range(0, 19);
                case (k / 3)
                    0: rop = LW;
                    1: rop = SW;
                    2: rop = RTYPE;
                    3: rop = BEQ;
                    4: rop = ADDI;
                    5: rop = J;
                    default: rop = (k == 18) ? 6'h3F : 6'($urandom);
                endcase
            end
            rz  = 1'($urandom);
            rmr = ($urandom_range(0, 9) < 7);
            drive(rr, rop, rz, rmr);
            @(negedge CLK);
            chk("rand_outputs", act_vec, expect_out(m_cur, rr, rmr, rz));
            m_step(rr, rop, rmr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
